// File: rtl/muldiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_seq : iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO        |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            abort,
   input  logic            wr_hi,
   input  logic            wr_lo,
   input  logic [XLEN-1:0] wdata,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic            div_by_zero,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int                c_CW   = $clog2(XLEN);
   localparam logic [c_CW-1:0]   c_LAST = c_CW'(XLEN - 1);
   localparam logic [c_CW-1:0]   c_ONE  = c_CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PREP = 2'd1,
      S_CALC = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t              r_state;
   logic [1:0]          r_op;
   logic [XLEN-1:0]     r_a, r_b, r_m;
   logic [2*XLEN-1:0]   r_acc;
   logic [c_CW-1:0]     r_cnt;
   logic                r_neg_p, r_neg_r, r_nowrite;
   logic                r_busy, r_done, r_dbz;
   logic [XLEN-1:0]     r_hi, r_lo;

   logic                w_is_div, w_signed;
   logic [XLEN-1:0]     w_abs_a, w_abs_b;
   logic [XLEN:0]       w_sum, w_shift, w_diff;
   logic [2*XLEN-1:0]   w_prod_fix;
   logic [XLEN-1:0]     w_quo_fix, w_rem_fix;

   assign w_is_div = r_op[1];
   assign w_signed = ~r_op[0];
   assign w_abs_a  = (w_signed && r_a[XLEN-1]) ? -r_a : r_a;
   assign w_abs_b  = (w_signed && r_b[XLEN-1]) ? -r_b : r_b;

   // Multiply: upper half accumulates, lower half holds the multiplier being shifted out.
   assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : '0);
   // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
   assign w_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
   assign w_diff  = w_shift - {1'b0, r_m};

   assign w_prod_fix = r_neg_p ? -r_acc : r_acc;
   assign w_quo_fix  = r_neg_p ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
   assign w_rem_fix  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state   <= S_IDLE;
         r_op      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_m       <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_neg_p   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_nowrite <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_dbz     <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_done <= 1'b0;
         r_dbz  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (wr_hi) r_hi <= wdata;
               if (wr_lo) r_lo <= wdata;
               if (start && !abort) begin
                  r_op    <= op;
                  r_a     <= src_a;
                  r_b     <= src_b;
                  r_busy  <= 1'b1;
                  r_state <= S_PREP;
               end
            end
            S_PREP: begin
               if (abort) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_neg_p <= w_signed & (r_a[XLEN-1] ^ r_b[XLEN-1]);
                  r_neg_r <= w_signed & r_a[XLEN-1];
                  r_cnt   <= '0;
                  if (w_is_div) begin
                     r_m       <= w_abs_b;
                     r_acc     <= {{XLEN{1'b0}}, w_abs_a};
                     r_nowrite <= (r_b == '0);
                     r_state   <= (r_b == '0) ? S_FIX : S_CALC;
                  end else begin
                     r_m       <= w_abs_a;
                     r_acc     <= {{XLEN{1'b0}}, w_abs_b};
                     r_nowrite <= 1'b0;
                     r_state   <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (abort) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  if (w_is_div) begin
                     if (!w_diff[XLEN])
                        r_acc <= {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
                     else
                        r_acc <= {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
                  end else begin
                     r_acc <= {w_sum, r_acc[XLEN-1:1]};
                  end
                  r_cnt <= r_cnt + c_ONE;
                  if (r_cnt == c_LAST) r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
               if (!abort) begin
                  r_done <= 1'b1;
                  if (r_nowrite) begin
                     r_dbz <= 1'b1;
                  end else if (w_is_div) begin
                     r_hi <= w_rem_fix;
                     r_lo <= w_quo_fix;
                  end else begin
                     r_hi <= w_prod_fix[2*XLEN-1:XLEN];
                     r_lo <= w_prod_fix[XLEN-1:0];
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy        = r_busy;
   assign stall       = r_busy;
   assign done        = r_done;
   assign div_by_zero = r_dbz;
   assign hi          = r_hi;
   assign lo          = r_lo;

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer that owns the HI/LO register pair for the MIPS core. It sits beside the EX stage. EX issues MULT/MULTU/DIV/DIVU with the two register operands. The block runs a 32-iteration shift-add (multiply) or restoring (divide) loop, then commits HI/LO. While busy it holds `stall` high so the pipeline does not issue dependent MFHI/MFLO, MTHI/MTLO or another mult/div.

## Interface
Parameters:
- `XLEN`, 32, operand/HI/LO width; iteration count equals `XLEN`.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  reset, synchronous, active-low.
- `start`  in  1  request an operation; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `src_a`  in  XLEN  rs operand (multiplicand / dividend).
- `src_b`  in  XLEN  rt operand (multiplier / divisor).
- `abort`  in  1  cancel in-flight operation (pipeline flush).
- `wr_hi`, `wr_lo`  in  1 each  MTHI/MTLO write enables.
- `wdata`  in  XLEN  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `stall`  out  1  equals `busy`; pipeline hold request.
- `done`  out  1  one-cycle pulse when an operation completes.
- `div_by_zero`  out  1  one-cycle pulse with `done` for DIV/DIVU with `src_b`=0.
- `hi`, `lo`  out  XLEN  architectural HI/LO registers.

## Operation
- States: IDLE, PREP, CALC, FIX.
- **Reset** (`RST`=0 at an edge):
  - Next state is IDLE.
  - `hi`, `lo`, `busy`, `stall`, `done`, `div_by_zero` and the iteration counter all go to 0.
  - Reset has priority over everything else.
- **IDLE**:
  - `start`=1 and `abort`=0: latch `op`, `src_a`, `src_b`; go to PREP.
  - `wr_hi`/`wr_lo` update `hi`/`lo` from `wdata`. A write in the same cycle as `start` is applied, and the operation result later overwrites it.
- **PREP** (1 cycle):
  - Signed ops (MULT, DIV): record result signs and load operand magnitudes. Product sign is `a[31]^b[31]`. Quotient sign is `a[31]^b[31]`. Remainder sign is `a[31]`.
  - Unsigned ops: load operands as-is.
  - DIV/DIVU with divisor 0: skip CALC, go to FIX with a no-write flag set.
  - Otherwise: clear the counter and go to CALC.
- **CALC** (exactly XLEN cycles, counter 0..XLEN-1):
  - Multiply: one shift-add step per cycle into a 2·XLEN accumulator.
  - Divide: one restoring step per cycle. Remainder width is XLEN+1 bits.
  - Counter reaching XLEN-1 moves the state to FIX.
- **FIX** (1 cycle):
  - Apply sign correction by two's complement of the magnitude.
  - Multiply: `hi`/`lo` get the upper/lower halves of the product.
  - Divide: `hi` gets the remainder and `lo` gets the quotient.
  - No-write flag set: `hi`/`lo` are unchanged and `div_by_zero` pulses.
  - `done` pulses in all cases; go to IDLE.
- **Arithmetic rules**:
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives `lo`=0x80000000, `hi`=0.
  - All arithmetic wraps modulo 2^XLEN.
- **Ignored inputs**:
  - `start` outside IDLE is ignored.
  - `wr_hi`/`wr_lo` outside IDLE are ignored. The pipeline is stalled then, so these must not occur.
- **Abort**:
  - `abort`=1 in PREP/CALC/FIX sends the state to IDLE at that edge.
  - No `done`; `hi`/`lo` unchanged.
  - `abort` with `start` in IDLE: `start` is dropped.

## Timing
- Let edge E0 be the edge at which `start` is accepted.
- `busy`/`stall` are registered:
  - They rise after E0.
  - Normal operations: they fall after E0+34.
  - Divide-by-zero: they fall after E0+2.
- Normal operations:
  - `hi`/`lo` are updated at E0+34, and `done` is high for the cycle following E0+34.
  - That is 34 cycles from acceptance to visible result.
  - The next `start` can be accepted at E0+35.
- Divide-by-zero: `done` and `div_by_zero` are high for the cycle following E0+2.
- `done`/`div_by_zero` are deasserted on every other cycle.
- Abort at edge Ea: `busy`=0 in the cycle after Ea.

## Test plan
- Reset: hold `RST`=0 two cycles with `start`=1 → all outputs 0; `busy` stays 0 after release until a new `start`.
- MULT: `src_a`=0xFFFFFFFE (-2), `src_b`=0x00000003 → after 34 cycles `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA, one `done` pulse. Repeat as MULTU → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV: 0xFFFFFFF9 (-7) / 0x00000002 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0. DIVU 100/7 → `lo`=14, `hi`=2.
- Divide by zero: preload `hi`=0x11111111 and `lo`=0x22222222 via MTHI/MTLO; DIVU 5/0 → `done`=`div_by_zero`=1 after 2 cycles; `hi`/`lo` unchanged.
- Abort at CALC cycle 10 of MULTU 7×9 → `busy`=0 next cycle, no `done`, `hi`/`lo` keep prior values. A new MULTU 7×9 then gives `lo`=63, `hi`=0.
- Illegal inputs while busy: `start` with new operands and `wr_hi`=1 (`wdata`=0xDEADBEEF) → ignored; result matches the original operation, and `done` pulses exactly once.
